// File: rtl/touch_gesture_ctrl.sv
// Touch-panel front end: pen debounce, hit latch, grid / slider / button classification,
// saturating slider value with drag tracking. Define AUTOREPEAT_EN for button autorepeat.
module touch_gesture_ctrl #(
   parameter int unsigned COORD_W     = 8,
   parameter int unsigned VAL_W       = 8,
   parameter int unsigned DEB_SAMPLES = 3,
   parameter int unsigned RELEASE_CYC = 8,
   parameter int unsigned GRID_X0     = 7,
   parameter int unsigned GRID_Y0     = 7,
   parameter int unsigned CELL_W      = 19,
   parameter int unsigned CELL_H      = 8,
   parameter int unsigned COLS        = 12,
   parameter int unsigned ROWS        = 16,
   parameter int unsigned SLIDE_X0    = 40,
   parameter int unsigned SLIDE_X1    = 220,
   parameter int unsigned SLIDE_Y0    = 155,
   parameter int unsigned SLIDE_Y1    = 168,
   parameter int unsigned BTN_W       = 20,
   parameter int unsigned SLIDE_MAX   = 127,
   parameter int unsigned DRAG_TH     = 3
`ifdef AUTOREPEAT_EN
   ,
   parameter int unsigned REPEAT_DLY  = 100,
   parameter int unsigned REPEAT_CYC  = 20
`endif
) (
   input  logic               sys_clk,
   input  logic               iRST_n,
   input  logic [COORD_W-1:0] coord_x_i,
   input  logic [COORD_W-1:0] coord_y_i,
   input  logic               coord_valid_i,
   input  logic               penirq_n_i,
   input  logic               load_en_i,
   input  logic [VAL_W-1:0]   load_val_i,
   output logic               pressed_o,
   output logic               cell_valid_o,
   output logic [3:0]         cell_col_o,
   output logic [3:0]         cell_row_o,
   output logic [COORD_W-1:0] hit_x_o,
   output logic [COORD_W-1:0] hit_y_o,
   output logic [VAL_W-1:0]   slide_val_o,
   output logic               write_slide_o,
   output logic               drag_o
);

   localparam int unsigned SPAN     = SLIDE_X1 - SLIDE_X0 + 1;
   localparam int unsigned MINUS_X0 = SLIDE_X0 - BTN_W;
   localparam int unsigned PLUS_X1  = SLIDE_X1 + BTN_W;
   localparam logic [VAL_W-1:0] SMAX = VAL_W'(SLIDE_MAX);

   typedef enum logic [2:0] {StIdle, StDebounce, StPress, StHold, StRelease} state_e;
   typedef enum logic [1:0] {RgNone, RgMinus, RgPlus, RgBar} region_e;

   state_e               state_q, state_d;
   region_e              region_q, region_d;
   logic [1:0]           pen_sync_q;
   logic [15:0]          cnt_q, cnt_d;
   logic [COORD_W-1:0]   hit_x_q, hit_x_d, hit_y_q, hit_y_d;
   logic [VAL_W-1:0]     slide_q, slide_d, val_dec, val_inc, load_clamped;
   logic [3:0]           cell_col_q, cell_col_d, cell_row_q, cell_row_d, gcol, grow;
   logic                 drag_q, drag_d, write_q, write_d;
   logic                 pen_up, deb_done, far, in_grid, in_sy, in_minus, in_plus, in_bar;
   logic [31:0]          hx, hy, cx, dx;
`ifdef AUTOREPEAT_EN
   logic [15:0]          rep_q, rep_d;
`endif

   // Maps an x coordinate onto 0..SLIDE_MAX across the bar, clamping x to the bar span first.
   function automatic logic [VAL_W-1:0] scale(input logic [31:0] x);
      logic [31:0] xc, q;
      xc = (x < SLIDE_X0) ? SLIDE_X0 : ((x > SLIDE_X1) ? SLIDE_X1 : x);
      q  = ((xc - SLIDE_X0) * (SLIDE_MAX + 1)) / SPAN;
      if (q > SLIDE_MAX) q = SLIDE_MAX;
      return VAL_W'(q);
   endfunction

   assign pen_up   = pen_sync_q[1];
   assign deb_done = (32'(cnt_q) + 32'd1 >= DEB_SAMPLES);
   assign hx       = 32'(hit_x_q);
   assign hy       = 32'(hit_y_q);
   assign cx       = 32'(coord_x_i);
   assign dx       = (cx >= hx) ? (cx - hx) : (hx - cx);
   assign far      = (dx >= DRAG_TH);
   assign gcol     = 4'((hx - GRID_X0) / CELL_W);
   assign grow     = 4'((hy - GRID_Y0) / CELL_H);
   assign in_grid  = (hx >= GRID_X0) && (hy >= GRID_Y0) &&
                     (((hx - GRID_X0) / CELL_W) < COLS) && (((hy - GRID_Y0) / CELL_H) < ROWS);
   assign in_sy    = (hy >= SLIDE_Y0) && (hy <= SLIDE_Y1);
   assign in_minus = in_sy && (hx >= MINUS_X0) && (hx < SLIDE_X0);
   assign in_plus  = in_sy && (hx > SLIDE_X1) && (hx <= PLUS_X1);
   assign in_bar   = in_sy && (hx >= SLIDE_X0) && (hx <= SLIDE_X1);
   assign val_dec  = (slide_q == '0) ? '0 : slide_q - VAL_W'(1);
   assign val_inc  = (32'(slide_q) >= SLIDE_MAX) ? SMAX : slide_q + VAL_W'(1);
   assign load_clamped = (32'(load_val_i) > SLIDE_MAX) ? SMAX : load_val_i;
   assign write_d  = (slide_d != slide_q) && (state_q != StIdle);

   always_ff @(posedge sys_clk or negedge iRST_n) begin
      if (!iRST_n) state_q <= StIdle;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:     if (!pen_up) state_d = StDebounce;
         StDebounce: begin
            if (pen_up)                          state_d = StIdle;
            else if (coord_valid_i && deb_done)  state_d = StPress;
         end
         StPress:    state_d = StHold;
         StHold:     if (pen_up) state_d = StRelease;
         StRelease:  if (32'(cnt_q) + 32'd1 >= RELEASE_CYC) state_d = StIdle;
         default:    state_d = StIdle;
      endcase
   end

   always_comb begin
      pressed_o     = (state_q == StPress) || (state_q == StHold);
      cell_valid_o  = (state_q == StPress) && in_grid;
      cell_col_o    = cell_valid_o ? gcol : cell_col_q;
      cell_row_o    = cell_valid_o ? grow : cell_row_q;
      hit_x_o       = hit_x_q;
      hit_y_o       = hit_y_q;
      slide_val_o   = slide_q;
      write_slide_o = write_q;
      drag_o        = drag_q;
   end

   always_comb begin
      cnt_d      = cnt_q;
      hit_x_d    = hit_x_q;
      hit_y_d    = hit_y_q;
      region_d   = region_q;
      slide_d    = slide_q;
      drag_d     = drag_q;
      cell_col_d = cell_col_q;
      cell_row_d = cell_row_q;
`ifdef AUTOREPEAT_EN
      rep_d      = rep_q;
`endif
      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (load_en_i) slide_d = load_clamped;
         end
         StDebounce: begin
            if (!pen_up && coord_valid_i) begin
               cnt_d = cnt_q + 16'd1;
               if (deb_done) begin
                  hit_x_d = coord_x_i;
                  hit_y_d = coord_y_i;
               end
            end
         end
         StPress: begin
            cnt_d    = '0;
            drag_d   = 1'b0;
            region_d = RgNone;
`ifdef AUTOREPEAT_EN
            rep_d    = '0;
`endif
            if (in_grid) begin
               cell_col_d = gcol;
               cell_row_d = grow;
            end else if (in_minus) begin
               region_d = RgMinus;
               slide_d  = val_dec;
            end else if (in_plus) begin
               region_d = RgPlus;
               slide_d  = val_inc;
            end else if (in_bar) begin
               region_d = RgBar;
               slide_d  = scale(hx);
            end
         end
         StHold: begin
            // Pen-up takes priority over any coincident sample.
            if (pen_up) begin
               drag_d = 1'b0;
               cnt_d  = '0;
`ifdef AUTOREPEAT_EN
               rep_d  = '0;
`endif
            end else begin
               if (region_q == RgBar && coord_valid_i && (drag_q || far)) begin
                  drag_d  = 1'b1;
                  slide_d = scale(cx);
               end
`ifdef AUTOREPEAT_EN
               if (region_q == RgMinus || region_q == RgPlus) begin
                  if (32'(rep_q) + 32'd1 >= REPEAT_DLY) begin
                     rep_d   = 16'(REPEAT_DLY - REPEAT_CYC);
                     slide_d = (region_q == RgMinus) ? val_dec : val_inc;
                  end else begin
                     rep_d = rep_q + 16'd1;
                  end
               end
`endif
            end
         end
         StRelease: cnt_d = cnt_q + 16'd1;
         default: ;
      endcase
   end

   always_ff @(posedge sys_clk or negedge iRST_n) begin
      if (!iRST_n) begin
         pen_sync_q <= 2'b11;
         cnt_q      <= '0;
         hit_x_q    <= '0;
         hit_y_q    <= '0;
         region_q   <= RgNone;
         slide_q    <= '0;
         drag_q     <= 1'b0;
         write_q    <= 1'b0;
         cell_col_q <= '0;
         cell_row_q <= '0;
`ifdef AUTOREPEAT_EN
         rep_q      <= '0;
`endif
      end else begin
         pen_sync_q <= {pen_sync_q[0], penirq_n_i};
         cnt_q      <= cnt_d;
         hit_x_q    <= hit_x_d;
         hit_y_q    <= hit_y_d;
         region_q   <= region_d;
         slide_q    <= slide_d;
         drag_q     <= drag_d;
         write_q    <= write_d;
         cell_col_q <= cell_col_d;
         cell_row_q <= cell_row_d;
`ifdef AUTOREPEAT_EN
         rep_q      <= rep_d;
`endif
      end
   end

endmodule

// File: tb/tb_touch_gesture_ctrl.sv
// Randomised bench for touch_gesture_ctrl: gesture-level reference model feeds expected-event
// queues that a per-cycle monitor checks against the DUT, plus hand-computed anchor checks.
`timescale 1ns/1ps
module tb_touch_gesture_ctrl;

   localparam int GX0 = 7, GY0 = 7, CW = 19, CH = 8, NCOL = 12, NROW = 16;
   localparam int SX0 = 40, SX1 = 220, SY0 = 155, SY1 = 168, BW = 20;
   localparam int SMAX = 127, DTH = 3, RELC = 8;

   logic       sys_clk = 1'b0;
   logic       iRST_n;
   logic [7:0] coord_x, coord_y, load_val;
   logic       coord_valid, penirq_n, load_en;
   logic       pressed, cell_valid, write_slide, drag;
   logic [3:0] cell_col, cell_row;
   logic [7:0] hit_x, hit_y, slide_val;

   always #5 sys_clk = ~sys_clk;

   touch_gesture_ctrl dut (
      .sys_clk(sys_clk), .iRST_n(iRST_n),
      .coord_x_i(coord_x), .coord_y_i(coord_y), .coord_valid_i(coord_valid),
      .penirq_n_i(penirq_n), .load_en_i(load_en), .load_val_i(load_val),
      .pressed_o(pressed), .cell_valid_o(cell_valid), .cell_col_o(cell_col),
      .cell_row_o(cell_row), .hit_x_o(hit_x), .hit_y_o(hit_y), .slide_val_o(slide_val),
      .write_slide_o(write_slide), .drag_o(drag)
   );

   typedef struct {int col; int row;} cell_t;

   int    checks = 0, errors = 0;
   cell_t exp_cell_q[$];
   int    exp_val_q[$];
   int    shadow = 0, m_val = 0, hx = 0, m_region = 0;
   bit    m_drag = 0, mon_en = 0;
   int    wr_pulses = 0, cell_pulses = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // 1 grid cell, 2 minus, 3 plus, 4 bar, 0 nothing
   function automatic int classify(input int x, input int y);
      if (x >= GX0 && y >= GY0 && (x - GX0) / CW < NCOL && (y - GY0) / CH < NROW) return 1;
      if (y >= SY0 && y <= SY1) begin
         if (x >= SX0 - BW && x < SX0)  return 2;
         if (x > SX1 && x <= SX1 + BW)  return 3;
         if (x >= SX0 && x <= SX1)      return 4;
      end
      return 0;
   endfunction

   function automatic int scale(input int x);
      int xc, v;
      xc = (x < SX0) ? SX0 : ((x > SX1) ? SX1 : x);
      v  = (xc - SX0) * (SMAX + 1) / (SX1 - SX0 + 1);
      return (v > SMAX) ? SMAX : v;
   endfunction

   task automatic set_val(input int nv);
      if (nv != m_val) exp_val_q.push_back(nv);
      m_val = nv;
   endtask

   always @(negedge sys_clk) begin
      cell_t c;
      if (mon_en) begin
         if (cell_valid) begin
            cell_pulses++;
            if (exp_cell_q.size() > 0) begin
               c = exp_cell_q.pop_front();
               check("cell_col", int'(cell_col), c.col);
               check("cell_row", int'(cell_row), c.row);
            end else check("spurious cell_valid", int'(cell_valid), 0);
         end
         if (write_slide) begin
            wr_pulses++;
            if (exp_val_q.size() > 0) begin
               shadow = exp_val_q.pop_front();
               check("write_slide value", int'(slide_val), shadow);
            end else check("spurious write_slide", int'(write_slide), 0);
         end else begin
            check("slide_val steady", int'(slide_val), shadow);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   task automatic strobe(input int x, input int y);
      coord_x = 8'(x); coord_y = 8'(y); coord_valid = 1'b1;
      tick(1);
      coord_valid = 1'b0;
      tick(1);
   endtask

   task automatic press(input int x, input int y);
      cell_t c;
      m_region = classify(x, y);
      hx = x;
      m_drag = 0;
      case (m_region)
         1: begin c.col = (x - GX0) / CW; c.row = (y - GY0) / CH; exp_cell_q.push_back(c); end
         2: set_val(m_val > 0 ? m_val - 1 : 0);
         3: set_val(m_val < SMAX ? m_val + 1 : SMAX);
         4: set_val(scale(x));
         default: ;
      endcase
      penirq_n = 1'b0;
      tick(4);
      strobe($urandom_range(0, 255), $urandom_range(0, 255));
      strobe($urandom_range(0, 255), $urandom_range(0, 255));
      strobe(x, y);
      check("pressed in hold", int'(pressed), 1);
      check("hit_x", int'(hit_x), x);
      check("hit_y", int'(hit_y), y);
   endtask

   task automatic hold_sample(input int x);
      if (m_region == 4 && (m_drag || (x > hx ? x - hx : hx - x) >= DTH)) begin
         m_drag = 1;
         set_val(scale(x));
      end
      strobe(x, $urandom_range(0, 255));
      check("drag", int'(drag), int'(m_drag));
   endtask

   task automatic release_pen();
      penirq_n = 1'b1;
      m_drag = 0;
      tick(RELC + 6);
      check("pressed after release", int'(pressed), 0);
      check("drag after release", int'(drag), 0);
      check("events outstanding", exp_val_q.size() + exp_cell_q.size(), 0);
   endtask

   task automatic load(input int v);
      load_val = 8'(v); load_en = 1'b1;
      tick(1);
      load_en = 1'b0;
      m_val = (v > SMAX) ? SMAX : v;
      shadow = m_val;
   endtask

   task automatic do_reset();
      mon_en = 0;
      iRST_n = 1'b0;
      penirq_n = 1'b1; coord_valid = 1'b0; load_en = 1'b0;
      tick(2);
      check("rst pressed", int'(pressed), 0);
      check("rst cell_valid", int'(cell_valid), 0);
      check("rst cell_col", int'(cell_col), 0);
      check("rst hit_x", int'(hit_x), 0);
      check("rst slide_val", int'(slide_val), 0);
      check("rst write_slide", int'(write_slide), 0);
      check("rst drag", int'(drag), 0);
      exp_cell_q.delete(); exp_val_q.delete();
      m_val = 0; shadow = 0; m_drag = 0;
      iRST_n = 1'b1;
      tick(3);
      mon_en = 1;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int w0, c0, x, n;
      coord_x = '0; coord_y = '0; load_val = '0;
      do_reset();

      // Anchor: grid cell (50,33) -> col 2, row 3.
      c0 = cell_pulses;
      press(50, 33);
      check("grid pulses", cell_pulses - c0, 1);
      check("grid col literal", int'(cell_col), 2);
      check("grid row literal", int'(cell_row), 3);
      release_pen();

      // Anchor: two strobes then pen-up -> nothing, back in idle (load accepted).
      c0 = cell_pulses; w0 = wr_pulses;
      penirq_n = 1'b0; tick(4); strobe(50, 33); strobe(50, 33); penirq_n = 1'b1; tick(4);
      check("abort pulses", (cell_pulses - c0) + (wr_pulses - w0), 0);
      check("abort pressed", int'(pressed), 0);
      load(5);
      check("idle load", int'(slide_val), 5);
      load(0);

      // Anchor: bar tap at 130 -> 63 with a single write.
      w0 = wr_pulses;
      press(130, 160); tick(1);
      check("bar tap literal", int'(slide_val), 63);
      check("bar tap writes", wr_pulses - w0, 1);
      release_pen();

      // Anchor: saturated steps give no write.
      load(127); w0 = wr_pulses;
      press(230, 160); release_pen();
      check("plus sat value", int'(slide_val), 127);
      check("plus sat writes", wr_pulses - w0, 0);
      load(0); w0 = wr_pulses;
      press(30, 160); release_pen();
      check("minus sat value", int'(slide_val), 0);
      check("minus sat writes", wr_pulses - w0, 0);

      // Anchor: drag from 60 to 200, ignored load, pen-up beats coincident sample.
      press(60, 160); tick(1);
      check("drag start literal", int'(slide_val), 14);
      hold_sample(64);
      check("drag literal at 64", int'(drag), 1);
      for (int xi = 68; xi <= 200; xi += 4) hold_sample(xi);
      check("drag end literal", int'(slide_val), 113);
      load_val = 8'd3; load_en = 1'b1; tick(1); load_en = 1'b0;
      penirq_n = 1'b1; tick(2); strobe(40, 160);
      m_drag = 0;
      release_pen();
      check("pen-up wins", int'(slide_val), 113);

      // Anchor: pen activity during the release lockout is ignored.
      press(100, 50);
      penirq_n = 1'b1; tick(1); penirq_n = 1'b0; tick(1);
      c0 = cell_pulses;
      strobe(50, 33); strobe(50, 33); strobe(50, 33);
      penirq_n = 1'b1; tick(RELC + 6);
      check("lockout pulses", cell_pulses - c0, 0);
      check("lockout pressed", int'(pressed), 0);

      // Anchor: long hold on plus from 10.
      load(10); w0 = wr_pulses;
      press(230, 160);
`ifdef AUTOREPEAT_EN
      for (int v = 12; v <= 16; v++) exp_val_q.push_back(v);
      m_val = 16;
`endif
      tick(186);
      release_pen();
`ifdef AUTOREPEAT_EN
      check("hold plus value", int'(slide_val), 16);
      check("hold plus writes", wr_pulses - w0, 6);
`else
      check("hold plus value", int'(slide_val), 11);
      check("hold plus writes", wr_pulses - w0, 1);
`endif

      // Reset in the middle of a drag aborts without pulses.
      press(100, 160);
      hold_sample(150);
      do_reset();
      tick(10);
      check("post-reset pressed", int'(pressed), 0);

      // Randomised gestures.
      for (int it = 0; it < 40; it++) begin
         case ($urandom_range(0, 4))
            0: begin
               press($urandom_range(0, 255), $urandom_range(0, 150));
               n = $urandom_range(0, 3);
               for (int k = 0; k < n; k++) hold_sample($urandom_range(0, 255));
               release_pen();
            end
            1: begin
               press($urandom_range(30, 230), $urandom_range(150, 172));
               n = $urandom_range(0, 10);
               for (int k = 0; k < n; k++) begin
                  x = hx + $urandom_range(0, 60) - 30;
                  hold_sample(x < 0 ? 0 : (x > 255 ? 255 : x));
               end
               release_pen();
            end
            2: begin
               if ($urandom_range(0, 1) == 1) press($urandom_range(SX0 - BW, SX0 - 1), $urandom_range(SY0, SY1));
               else press($urandom_range(SX1 + 1, SX1 + BW), $urandom_range(SY0, SY1));
               hold_sample($urandom_range(0, 255));
               release_pen();
            end
            3: begin
               c0 = cell_pulses; w0 = wr_pulses;
               penirq_n = 1'b0; tick(4);
               n = $urandom_range(0, 2);
               for (int k = 0; k < n; k++) strobe($urandom_range(0, 255), $urandom_range(0, 255));
               penirq_n = 1'b1; tick(4);
               check("rand abort pulses", (cell_pulses - c0) + (wr_pulses - w0), 0);
            end
            default: begin
               load($urandom_range(0, 255));
               check("rand load", int'(slide_val), m_val);
            end
         endcase
      end

      tick(5);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
